// File: rtl/base_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : base_pkg
//  Brief    : Shared helpers for the thermometer counter family: reset
//             pattern generation and encoder width legality check.
//  Revision : 1.0 - initial release
// ============================================================================
package base_pkg;

    // Widest thermometer vector the helper functions can describe.
    localparam int c_therm_max_width = 64;

    // Reset pattern holding n ones from index 0 upward; bit j of the result
    // corresponds to thermometer bit j (index 0 is the first bit set).
    function automatic logic [c_therm_max_width-1:0] therm_init(input int width, input int n);
        logic [c_therm_max_width-1:0] v;
        v = '0;
        for (int j = 0; j < c_therm_max_width; j++) begin
            if (j < width && j < n) begin
                v[j] = 1'b1;
            end
        end
        return v;
    endfunction

    // True when an enc_width-bit binary value can represent 0..width.
    function automatic bit enc_width_ok(input int width, input int enc_width);
        if (enc_width >= 31) begin
            return 1'b1;
        end
        return ((1 << enc_width) > width);
    endfunction

endpackage : base_pkg
`default_nettype wire

// File: rtl/base_tenc.sv
`default_nettype none
// ============================================================================
//  Module   : base_tenc
//  Brief    : Thermometer-to-binary encoder. Input bit 0 is the first bit
//             set; output is the count with its MSB at index 0.
//  Revision : 1.0 - initial release
// ============================================================================
module base_tenc #(
    parameter int DEC_WIDTH = 4,
    parameter int ENC_WIDTH = 3
) (
    input  logic [0:DEC_WIDTH-1] i_therm,
    output logic [0:ENC_WIDTH-1] o_bin
);

    // Highest set position determines the count; a valid code has no gaps.
    always_comb begin
        o_bin = '0;
        for (int i = 0; i < DEC_WIDTH; i++) begin
            if (i_therm[i]) begin
                o_bin = ENC_WIDTH'(i + 1);
            end
        end
    end

endmodule : base_tenc
`default_nettype wire

// File: rtl/base_tcnt.sv
`default_nettype none
// ============================================================================
//  Module   : base_tcnt
//  Brief    : Thermometer-coded up/down occupancy counter with registered
//             binary copy, ready/full/empty decodes and sticky over/underflow.
//  Revision : 1.0 - initial release
// ============================================================================
module base_tcnt
    import base_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int ENC_WIDTH = 3,
    parameter int INIT      = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_inc,
    input  logic                 i_dec,
    input  logic                 i_clr_err,
    output logic [0:WIDTH-1]     o_t,
    output logic [0:ENC_WIDTH-1] o_cnt,
    output logic                 o_full,
    output logic                 o_empty,
    output logic                 o_inc_rdy,
    output logic                 o_dec_rdy,
    output logic                 o_ovf,
    output logic                 o_unf
);

    localparam logic [c_therm_max_width-1:0] c_init_vec = therm_init(WIDTH, INIT);

    // Parameter legality, rejected at elaboration.
    if (WIDTH < 1) begin : g_bad_width
        $error("base_tcnt: WIDTH must be at least 1");
    end
    if (WIDTH > c_therm_max_width) begin : g_bad_width_max
        $error("base_tcnt: WIDTH exceeds supported maximum");
    end
    if (!enc_width_ok(WIDTH, ENC_WIDTH)) begin : g_bad_enc_width
        $error("base_tcnt: ENC_WIDTH too narrow to hold WIDTH");
    end
    if (INIT < 0 || INIT > WIDTH) begin : g_bad_init
        $error("base_tcnt: INIT must lie in 0..WIDTH");
    end

    logic [0:WIDTH-1]     r_t;
    logic [0:ENC_WIDTH-1] r_cnt;
    logic                 r_ovf;
    logic                 r_unf;

    logic [0:WIDTH-1]     w_t_up;
    logic [0:WIDTH-1]     w_t_dn;
    logic [0:WIDTH-1]     w_t_nxt;
    logic [0:ENC_WIDTH-1] w_cnt_nxt;
    logic                 w_full;
    logic                 w_empty;
    logic                 w_inc_only;
    logic                 w_dec_only;
    logic                 w_ovf_set;
    logic                 w_unf_set;

    // Boundary decodes come straight off the state register.
    assign w_full     = r_t[WIDTH-1];
    assign w_empty    = ~r_t[0];
    assign w_inc_only = i_inc & ~i_dec;
    assign w_dec_only = i_dec & ~i_inc;
    assign w_ovf_set  = w_inc_only & w_full;
    assign w_unf_set  = w_dec_only & w_empty;

    // Shifted candidates: up fills a 1 at index 0, down drops the last 1.
    always_comb begin
        w_t_up    = '0;
        w_t_dn    = '0;
        w_t_up[0] = 1'b1;
        for (int j = 1; j < WIDTH; j++) begin
            w_t_up[j] = r_t[j-1];
        end
        for (int j = 0; j < WIDTH - 1; j++) begin
            w_t_dn[j] = r_t[j+1];
        end
    end

    // Next-state selection; illegal or paired requests leave the code intact.
    always_comb begin
        w_t_nxt = r_t;
        if (w_inc_only && !w_full) begin
            w_t_nxt = w_t_up;
        end else if (w_dec_only && !w_empty) begin
            w_t_nxt = w_t_dn;
        end
    end

    // Binary copy is derived from the next-state code so it tracks r_t.
    base_tenc #(
        .DEC_WIDTH (WIDTH),
        .ENC_WIDTH (ENC_WIDTH)
    ) u_tenc (
        .i_therm (w_t_nxt),
        .o_bin   (w_cnt_nxt)
    );

    // State, binary copy and sticky errors; a fresh error beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < WIDTH; j++) begin
                r_t[j] <= c_init_vec[j];
            end
            r_cnt <= ENC_WIDTH'(INIT);
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_t   <= w_t_nxt;
            r_cnt <= w_cnt_nxt;
            r_ovf <= w_ovf_set | (r_ovf & ~i_clr_err);
            r_unf <= w_unf_set | (r_unf & ~i_clr_err);
        end
    end

    assign o_t       = r_t;
    assign o_cnt     = r_cnt;
    assign o_full    = w_full;
    assign o_empty   = w_empty;
    assign o_inc_rdy = ~w_full;
    assign o_dec_rdy = ~w_empty;
    assign o_ovf     = r_ovf;
    assign o_unf     = r_unf;

endmodule : base_tcnt
`default_nettype wire

// File: tb/tb_base_tcnt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_base_tcnt
//  Brief    : Self-checking bench for base_tcnt against an integer
//             occupancy model; directed boundary cases plus random soak.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_base_tcnt;

    localparam int WIDTH     = 4;
    localparam int ENC_WIDTH = 3;
    localparam int INIT      = 2;

    logic                 clk;
    logic                 reset;
    logic                 inc;
    logic                 dec;
    logic                 clr_err;
    logic [0:WIDTH-1]     t;
    logic [0:ENC_WIDTH-1] cnt;
    logic                 full;
    logic                 empty;
    logic                 inc_rdy;
    logic                 dec_rdy;
    logic                 ovf;
    logic                 unf;

    int n_checks;
    int n_errors;

    // Reference model: plain occupancy integer and two sticky flags.
    int m_cnt;
    bit m_ovf;
    bit m_unf;

    base_tcnt #(
        .WIDTH     (WIDTH),
        .ENC_WIDTH (ENC_WIDTH),
        .INIT      (INIT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .i_inc     (inc),
        .i_dec     (dec),
        .i_clr_err (clr_err),
        .o_t       (t),
        .o_cnt     (cnt),
        .o_full    (full),
        .o_empty   (empty),
        .o_inc_rdy (inc_rdy),
        .o_dec_rdy (dec_rdy),
        .o_ovf     (ovf),
        .o_unf     (unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, $time);
        end
    endtask

    // Compare every output against the model's view of the count.
    task automatic check_all();
        logic [0:WIDTH-1] exp_t;
        for (int j = 0; j < WIDTH; j++) begin
            exp_t[j] = (j < m_cnt);
        end
        chk("therm",    32'(t),   32'(exp_t));
        chk("cnt",      32'(cnt), 32'(m_cnt));
        chk("popcount", 32'(cnt), 32'($countones(t)));
        chk("full",     32'(full),    32'(m_cnt == WIDTH));
        chk("empty",    32'(empty),   32'(m_cnt == 0));
        chk("inc_rdy",  32'(inc_rdy), 32'(m_cnt != WIDTH));
        chk("dec_rdy",  32'(dec_rdy), 32'(m_cnt != 0));
        chk("ovf",      32'(ovf), 32'(m_ovf));
        chk("unf",      32'(unf), 32'(m_unf));
    endtask

    // One clock: drive on the falling edge, advance model at the rising
    // edge, then sample just after it.
    task automatic step(input bit r, input bit i, input bit d, input bit c);
        bit oe;
        bit ue;
        @(negedge clk);
        reset   = r;
        inc     = i;
        dec     = d;
        clr_err = c;
        @(posedge clk);
        if (r) begin
            m_cnt = INIT;
            m_ovf = 0;
            m_unf = 0;
        end else begin
            oe = i && !d && (m_cnt == WIDTH);
            ue = d && !i && (m_cnt == 0);
            if (i && !d && m_cnt < WIDTH) m_cnt = m_cnt + 1;
            else if (d && !i && m_cnt > 0) m_cnt = m_cnt - 1;
            m_ovf = oe || (m_ovf && !c);
            m_unf = ue || (m_unf && !c);
        end
        #1;
        check_all();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_cnt    = 0;
        m_ovf    = 0;
        m_unf    = 0;
        reset    = 1'b1;
        inc      = 1'b0;
        dec      = 1'b0;
        clr_err  = 1'b0;

        // Reset: expect 1100, count 2, no flags.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        // Drain to empty, then fill with five incs (last one overflows).
        step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        for (int k = 0; k < 5; k++) step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        // Back to empty, underflow, clear racing a new underflow, clear.
        for (int k = 0; k < 4; k++) step(0, 0, 1, 0);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);
        step(0, 0, 0, 1);

        // Simultaneous inc+dec at counts 0, 2 and 4.
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);

        // Reset mid-stream at count 3 with an inc pending.
        step(0, 0, 1, 0);
        step(1, 1, 0, 0);
        step(0, 0, 0, 0);

        // Random soak.
        for (int k = 0; k < 10000; k++) begin
            step(($urandom_range(255) == 0),
                 ($urandom_range(1) == 1),
                 ($urandom_range(1) == 1),
                 ($urandom_range(7) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_base_tcnt
`default_nettype wire

// File: doc/base_tcnt.md
# base_tcnt

Thermometer-coded up/down occupancy counter for credit and FIFO-fill tracking. It holds its count as a thermometer vector: 0 = all zeros, 1 = `10..0`, 2 = `110..0`, and so on. The vector and a registered binary copy are exported together. Downstream logic can compare thresholds on single thermometer bits or use the binary count directly; the binary copy comes from the codebase thermometer encoder `base_tenc`.

## Interface
- `width`, default 4: maximum count; thermometer vector length.
- `enc_width`, default 3: binary count width; must satisfy 2^enc_width > width.
- `init`, default 0: count loaded at reset, 0..width.
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_inc`  in  1  increment request this cycle.
- `i_dec`  in  1  decrement request this cycle.
- `i_clr_err`  in  1  clears sticky error flags.
- `o_t`  out  [0:width-1]  thermometer count; bit 0 is the first bit set.
- `o_cnt`  out  [0:enc_width-1]  binary count, MSB at index 0.
- `o_full`  out  1  count == width (equals `o_t[width-1]`).
- `o_empty`  out  1  count == 0 (equals `~o_t[0]`).
- `o_inc_rdy`  out  1  `~o_full`.
- `o_dec_rdy`  out  1  `~o_empty`.
- `o_ovf`  out  1  sticky overflow error.
- `o_unf`  out  1  sticky underflow error.

## Operation
- State is a `width`-bit thermometer register `t` plus sticky `ovf` and `unf` bits.
- `o_t` is `t` directly. `o_cnt` is registered.
- **Reset:** `t` = `init` ones followed by zeros. `ovf` = `unf` = 0. `o_cnt` = `init`.
- **Update, each cycle when not in reset:**
  - inc only, not full: `t <= {1'b1, t[0:width-2]}` (shift right, fill with 1).
  - dec only, not empty: `t <= {t[1:width-1], 1'b0}` (shift left, fill with 0).
  - inc and dec together: `t` holds. This is legal at every count, including full and empty.
  - inc only while full: `t` holds and `ovf` sets.
  - dec only while empty: `t` holds and `unf` sets.
  - neither: `t` holds.
- **Error flags:**
  - `i_clr_err` clears `ovf` and `unf`.
  - If a new error occurs in the same cycle as `i_clr_err`, the new error wins and the flag stays or becomes 1.
- **Invariant:** `t` is always a valid thermometer code, with no 0 followed later by a 1. Illegal requests never corrupt it.
- `o_cnt` is registered as the encoded value of the next-state `t`. `o_t` and `o_cnt` therefore always describe the same count in the same cycle.
- **Width rules:**
  - `width` ≥ 1.
  - `width` = 1 degenerates to a single flag; inc and dec shift in 1 and 0 respectively.
  - `init` > `width` is illegal and must be flagged by an elaboration-time check.

## Timing
- Inc/dec to `o_t`, `o_cnt`, `o_full`, `o_empty`, `o_inc_rdy`, `o_dec_rdy`: 1 cycle, visible the cycle after the request edge.
- Error to `o_ovf`/`o_unf`: 1 cycle.
- `o_full`, `o_empty`, `o_inc_rdy`, `o_dec_rdy` are pure decodes of `t`. No extra register and no dependence on current-cycle requests, so no combinational path from inputs to outputs.
- Reset asserted mid-stream overrides every request in that cycle. The first post-reset update uses requests from the cycle after reset deasserts.
- Throughput: one inc and/or one dec accepted per cycle, with no bubbles.

## Structure
- Shared package `base_pkg`:
  - a function `therm_init(width, n)` returning the `n`-ones reset pattern;
  - the legality check `2**enc_width > width` as a reusable function.
- One sub-module: `base_tenc` (`dec_width=width`, `enc_width=enc_width`). It is fed the next-state `t` and its output is registered into `o_cnt`.
- The thermometer-to-binary conversion lives only in that sub-module, never duplicated inline.

## Test plan
- **Reset and boundary flags:** `width`=4, `init`=2, `reset` high for 1 cycle → `o_t`=`1100`, `o_cnt`=2, `o_full`=0, `o_empty`=0, `o_ovf`=0, `o_unf`=0.
- **Fill to full, then overflow:** from 0, `i_inc`=1 for 5 cycles → `o_t` steps `1000`, `1100`, `1110`, `1111` with `o_cnt` 1..4. `o_full`=1 at count 4. The 5th inc leaves `1111` and sets `o_ovf`=1.
- **Underflow and clear:** at empty, `i_dec`=1 → `o_t`=`0000` unchanged, `o_unf`=1. Then `i_clr_err`=1 together with another dec at empty → `o_unf` stays 1. Then `i_clr_err` alone → `o_unf`=0.
- **Simultaneous requests:** `i_inc`=`i_dec`=1 at counts 0, 2 and 4 → count unchanged, no error flags at any of the three.
- **Reset mid-stream:** at count 3 with `i_inc`=1, assert `reset` → next cycle `o_t`=`init` pattern and errors 0.
- **Random soak:** ≥10k cycles of random inc/dec/clr against a reference integer model. Each cycle `o_t` must be a valid thermometer code, `o_cnt` must equal popcount(`o_t`), and the flags must match the model.
